// File: rtl/acc_task_scheduler_pkg.sv
// Shared constants and state types for the accelerator task scheduler.
// Defines the command header field positions, the setup command code,
// the merged-stream destination id and the dispatch/completion FSM states.
package OmpSsManager;

  localparam int CMD_TYPE_H = 7;
  localparam int CMD_TYPE_L = 0;
  localparam int ACC_SEL_H  = 15;
  localparam int ACC_SEL_L  = 8;

  localparam logic [7:0] SETUP_HW_INST_CODE = 8'h02;
  localparam logic [7:0] HWR_CMDOUT_ID      = 8'h11;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_FWD  = 2'd1,
    D_DROP = 2'd2
  } disp_state_e;

  typedef enum logic {
    C_IDLE = 1'b0,
    C_FWD  = 1'b1
  } cmp_state_e;

  // Index width for n accelerators, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_task_scheduler_rr_pick.sv
// Round-robin finder: returns the first set request bit at or after ptr,
// wrapping around past the top bit. Purely combinational.
module rr_pick
  import OmpSsManager::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    int k;
    k     = 0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!found && req[k]) begin
        found = 1'b1;
        idx   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/acc_task_scheduler.sv
// Task scheduler between the manager command stream and an accelerator array.
// Dispatches packets to idle accelerators round-robin, tracks busy bits and
// merges the per-accelerator completion streams packet-atomically.
// Optional statistics counters are enabled with the SCHED_STATS_EN macro.
module acc_task_scheduler
  import OmpSsManager::*;
#(
  parameter int NUM_ACCS    = 4,
  parameter int ACC_ID_BASE = 0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic [63:0]              in_data,
  output logic [NUM_ACCS-1:0]      acc_in_valid,
  input  logic [NUM_ACCS-1:0]      acc_in_ready,
  output logic [63:0]              acc_in_data,
  output logic                     acc_in_last,
  input  logic [NUM_ACCS-1:0]      acc_out_valid,
  output logic [NUM_ACCS-1:0]      acc_out_ready,
  input  logic [NUM_ACCS-1:0]      acc_out_last,
  input  logic [64*NUM_ACCS-1:0]   acc_out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [63:0]              out_data,
  output logic [7:0]               out_id,
  output logic [7:0]               out_dest,
`ifdef SCHED_STATS_EN
  output logic [31:0]              stat_dispatched,
  output logic [31:0]              stat_completed,
  output logic [31:0]              stat_dropped,
`endif
  output logic [NUM_ACCS-1:0]      busy
);

  localparam int IDX_W = idx_width(NUM_ACCS);

  disp_state_e         disp_q, disp_d;
  logic [IDX_W-1:0]    target_q, target_d;
  logic [IDX_W-1:0]    rr_disp_q, rr_disp_d;
  logic                is_task_q, is_task_d;
  logic                first_q, first_d;

  cmp_state_e          cmp_q, cmp_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    rr_cmp_q, rr_cmp_d;

  logic [NUM_ACCS-1:0] busy_q, busy_d;
  logic [NUM_ACCS-1:0] set_mask, clr_mask;
  logic [NUM_ACCS-1:0] idle_mask;

  logic                free_found, cmp_found;
  logic [IDX_W-1:0]    free_idx, cmp_idx;

  logic [7:0]          hdr_type, hdr_sel;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_ACCS - 1) ? '0 : i + IDX_W'(1);
  endfunction

  assign hdr_type  = in_data[CMD_TYPE_H:CMD_TYPE_L];
  assign hdr_sel   = in_data[ACC_SEL_H:ACC_SEL_L];
  assign idle_mask = ~busy_q;

  rr_pick #(.N(NUM_ACCS), .IDX_W(IDX_W)) u_pick_disp (
    .req   (idle_mask),
    .ptr   (rr_disp_q),
    .found (free_found),
    .idx   (free_idx)
  );

  rr_pick #(.N(NUM_ACCS), .IDX_W(IDX_W)) u_pick_cmp (
    .req   (acc_out_valid),
    .ptr   (rr_cmp_q),
    .found (cmp_found),
    .idx   (cmp_idx)
  );

  assign acc_in_data = in_data;
  assign acc_in_last = in_last;

  // Dispatch: choose a target from the unconsumed header, then pass beats through.
  always_comb begin
    disp_d       = disp_q;
    target_d     = target_q;
    is_task_d    = is_task_q;
    first_d      = first_q;
    rr_disp_d    = rr_disp_q;
    set_mask     = '0;
    in_ready     = 1'b0;
    acc_in_valid = '0;
    unique case (disp_q)
      D_IDLE: begin
        if (in_valid) begin
          if (hdr_type == SETUP_HW_INST_CODE) begin
            if (int'(hdr_sel) >= NUM_ACCS) begin
              disp_d = D_DROP;
            end else if (!busy_q[hdr_sel[IDX_W-1:0]]) begin
              disp_d    = D_FWD;
              target_d  = hdr_sel[IDX_W-1:0];
              is_task_d = 1'b0;
              first_d   = 1'b1;
            end
          end else if (free_found) begin
            disp_d    = D_FWD;
            target_d  = free_idx;
            is_task_d = 1'b1;
            first_d   = 1'b1;
            rr_disp_d = wrap_inc(free_idx);
          end
        end
      end
      D_FWD: begin
        acc_in_valid[target_q] = in_valid;
        in_ready               = acc_in_ready[target_q];
        if (in_valid && in_ready) begin
          first_d = 1'b0;
          if (first_q && is_task_q) set_mask[target_q] = 1'b1;
          if (in_last) disp_d = D_IDLE;
        end
      end
      D_DROP: begin
        in_ready = 1'b1;
        if (in_valid && in_last) disp_d = D_IDLE;
      end
      default: disp_d = D_IDLE;
    endcase
  end

  // Completion arbiter: lock a source for a whole packet, release busy on its last beat.
  always_comb begin
    cmp_d         = cmp_q;
    grant_d       = grant_q;
    rr_cmp_d      = rr_cmp_q;
    clr_mask      = '0;
    acc_out_ready = '0;
    out_valid     = 1'b0;
    out_last      = 1'b0;
    unique case (cmp_q)
      C_IDLE: begin
        if (cmp_found) begin
          cmp_d    = C_FWD;
          grant_d  = cmp_idx;
          rr_cmp_d = wrap_inc(cmp_idx);
        end
      end
      C_FWD: begin
        out_valid              = acc_out_valid[grant_q];
        out_last               = acc_out_last[grant_q];
        acc_out_ready[grant_q] = out_ready;
        if (out_valid && out_ready && out_last) begin
          clr_mask[grant_q] = 1'b1;
          cmp_d             = C_IDLE;
        end
      end
      default: cmp_d = C_IDLE;
    endcase
  end

  assign out_data = acc_out_data[int'(grant_q)*64 +: 64];
  assign out_id   = 8'(ACC_ID_BASE + int'(grant_q));
  assign out_dest = HWR_CMDOUT_ID;

  // Sets and clears never target the same bit, so both apply independently.
  assign busy_d = (busy_q & ~clr_mask) | set_mask;
  assign busy   = busy_q;

  // State registers for both FSMs, the round-robin pointers and the busy bits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      disp_q    <= D_IDLE;
      target_q  <= '0;
      rr_disp_q <= '0;
      is_task_q <= 1'b0;
      first_q   <= 1'b0;
      cmp_q     <= C_IDLE;
      grant_q   <= '0;
      rr_cmp_q  <= '0;
      busy_q    <= '0;
    end else begin
      disp_q    <= disp_d;
      target_q  <= target_d;
      rr_disp_q <= rr_disp_d;
      is_task_q <= is_task_d;
      first_q   <= first_d;
      cmp_q     <= cmp_d;
      grant_q   <= grant_d;
      rr_cmp_q  <= rr_cmp_d;
      busy_q    <= busy_d;
    end
  end

`ifdef SCHED_STATS_EN
  logic        task_hs, cmp_hs, drop_ev;
  logic [31:0] stat_disp_q, stat_disp_d;
  logic [31:0] stat_cmp_q, stat_cmp_d;
  logic [31:0] stat_drop_q, stat_drop_d;

  assign task_hs = (disp_q == D_FWD) && first_q && is_task_q && in_valid && in_ready;
  assign cmp_hs  = (cmp_q == C_FWD) && out_valid && out_ready && out_last;
  assign drop_ev = (disp_q == D_IDLE) && (disp_d == D_DROP);

  // Event counters wrap naturally at 32 bits.
  always_comb begin
    stat_disp_d = stat_disp_q + 32'(task_hs);
    stat_cmp_d  = stat_cmp_q + 32'(cmp_hs);
    stat_drop_d = stat_drop_q + 32'(drop_ev);
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_disp_q <= '0;
      stat_cmp_q  <= '0;
      stat_drop_q <= '0;
    end else begin
      stat_disp_q <= stat_disp_d;
      stat_cmp_q  <= stat_cmp_d;
      stat_drop_q <= stat_drop_d;
    end
  end

  assign stat_dispatched = stat_disp_q;
  assign stat_completed  = stat_cmp_q;
  assign stat_dropped    = stat_drop_q;
`endif

endmodule

// File: tb/tb_acc_task_scheduler.sv
// Directed bench for acc_task_scheduler with four accelerators.
// Stat counter checks are included when SCHED_STATS_EN is defined.
module tb_acc_task_scheduler;
  import OmpSsManager::*;

  localparam int N = 4;

  logic           clk  = 1'b0;
  logic           rstn = 1'b1;
  logic           in_valid, in_ready, in_last;
  logic [63:0]    in_data;
  logic [N-1:0]   acc_in_valid, acc_in_ready;
  logic [63:0]    acc_in_data;
  logic           acc_in_last;
  logic [N-1:0]   acc_out_valid, acc_out_ready, acc_out_last;
  logic [64*N-1:0] acc_out_data;
  logic           out_valid, out_ready, out_last;
  logic [63:0]    out_data;
  logic [7:0]     out_id, out_dest;
  logic [N-1:0]   busy;
`ifdef SCHED_STATS_EN
  logic [31:0]    stat_dispatched, stat_completed, stat_dropped;
`endif

  logic           tb_ov[N];
  logic           tb_ol[N];
  logic [63:0]    tb_od[N];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  id;
    logic [7:0]  dest;
    logic [63:0] data;
    logic        last;
  } beat_t;
  beat_t mon_q[$];

  typedef struct {
    logic [63:0] hdr;
    int          exp_acc;
    logic [3:0]  exp_busy;
  } vec_t;
  vec_t vecs[4];

  localparam logic [63:0] TASK_HDR = 64'h0000_1234_0000_0001;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign acc_out_valid[g]          = tb_ov[g];
    assign acc_out_last[g]           = tb_ol[g];
    assign acc_out_data[64*g +: 64]  = tb_od[g];
  end

  acc_task_scheduler #(.NUM_ACCS(N), .ACC_ID_BASE(0)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_last         (in_last),
    .in_data         (in_data),
    .acc_in_valid    (acc_in_valid),
    .acc_in_ready    (acc_in_ready),
    .acc_in_data     (acc_in_data),
    .acc_in_last     (acc_in_last),
    .acc_out_valid   (acc_out_valid),
    .acc_out_ready   (acc_out_ready),
    .acc_out_last    (acc_out_last),
    .acc_out_data    (acc_out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_last        (out_last),
    .out_data        (out_data),
    .out_id          (out_id),
    .out_dest        (out_dest),
`ifdef SCHED_STATS_EN
    .stat_dispatched (stat_dispatched),
    .stat_completed  (stat_completed),
    .stat_dropped    (stat_dropped),
`endif
    .busy            (busy)
  );

  // Record every beat handed over on the merged completion stream.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready)
      mon_q.push_back('{id: out_id, dest: out_dest, data: out_data, last: out_last});
  end

  function automatic logic [63:0] cmpWord(input int k, input int b);
    return {8'hC0, 8'(k), 8'(b), 32'h0000_0000, 8'h03};
  endfunction

  function automatic logic [63:0] setupHdr(input logic [7:0] sel);
    return {48'h0, sel, SETUP_HW_INST_CODE};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Send one packet on the command stream; exp_acc < 0 means it must be dropped.
  task automatic applyStimulus(input logic [63:0] hdr, input int nbeats, input int exp_acc,
                               output int cycles);
    int beat;
    beat   = 0;
    cycles = 0;
    while (beat < nbeats && cycles < 60) begin
      in_valid = 1'b1;
      in_data  = (beat == 0) ? hdr : (64'hDA7A_0000_0000_0000 | 64'(beat));
      in_last  = (beat == nbeats - 1);
      @(negedge clk);
      if (in_ready) begin
        checkOutput("acc_in_valid", 64'(acc_in_valid),
                    (exp_acc < 0) ? 64'(0) : (64'(1) << exp_acc));
        if (exp_acc >= 0) checkOutput("acc_in_data", acc_in_data, in_data);
        beat++;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    if (beat < nbeats) begin
      checks++;
      failures++;
      $display("[TB] FAIL dispatch_timeout: got %0d beats expected %0d", beat, nbeats);
    end
  endtask

  // Drive a 3-word style completion packet from accelerator k.
  task automatic sendCompletion(input int k, input int nbeats);
    int beat;
    int cyc;
    beat = 0;
    cyc  = 0;
    while (beat < nbeats && cyc < 80) begin
      tb_ov[k] = 1'b1;
      tb_od[k] = cmpWord(k, beat);
      tb_ol[k] = (beat == nbeats - 1);
      @(negedge clk);
      if (acc_out_ready[k]) beat++;
      @(posedge clk);
      #1;
      cyc++;
    end
    tb_ov[k] = 1'b0;
    tb_ol[k] = 1'b0;
    if (beat < nbeats) begin
      checks++;
      failures++;
      $display("[TB] FAIL completion_timeout acc=%0d: got %0d beats expected %0d", k, beat, nbeats);
    end
  endtask

  // Pop three merged beats and compare them with accelerator k's packet.
  task automatic checkPacket(input int k);
    beat_t b;
    for (int i = 0; i < 3; i++) begin
      if (mon_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL out_beat acc=%0d beat=%0d: got none expected one", k, i);
      end else begin
        b = mon_q.pop_front();
        checkOutput("out_id", 64'(b.id), 64'(k));
        checkOutput("out_data", b.data, cmpWord(k, i));
        checkOutput("out_last", 64'(b.last), 64'(i == 2));
        checkOutput("out_dest", 64'(b.dest), 64'(HWR_CMDOUT_ID));
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    vecs[0] = '{hdr: TASK_HDR | 64'h10_0000, exp_acc: 0, exp_busy: 4'b0001};
    vecs[1] = '{hdr: TASK_HDR | 64'h20_0000, exp_acc: 1, exp_busy: 4'b0011};
    vecs[2] = '{hdr: TASK_HDR | 64'h30_0000, exp_acc: 2, exp_busy: 4'b0111};
    vecs[3] = '{hdr: TASK_HDR | 64'h40_0000, exp_acc: 3, exp_busy: 4'b1111};

    in_valid     = 1'b0;
    in_last      = 1'b0;
    in_data      = '0;
    acc_in_ready = '1;
    out_ready    = 1'b1;
    for (int k = 0; k < N; k++) begin
      tb_ov[k] = 1'b0;
      tb_ol[k] = 1'b0;
      tb_od[k] = '0;
    end

    // Reset state
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", 64'(in_ready), 64'(0));
    checkOutput("reset_acc_in_valid", 64'(acc_in_valid), 64'(0));
    checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
    checkOutput("reset_acc_out_ready", 64'(acc_out_ready), 64'(0));
    checkOutput("reset_busy", 64'(busy), 64'(0));
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Four tasks fill the accelerators in round-robin order
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].hdr, 3, vecs[i].exp_acc, cyc);
      checkOutput("busy_after_task", 64'(busy), 64'(vecs[i].exp_busy));
      if (i == 0) checkOutput("dispatch_cycles", 64'(cyc), 64'(4));
    end

    // Fifth task stalls until accelerator 2 completes
    mon_q.delete();
    fork
      applyStimulus(TASK_HDR | 64'h50_0000, 3, 2, cyc);
      begin
        repeat (4) begin
          @(negedge clk);
          checkOutput("stall_in_ready", 64'(in_ready), 64'(0));
        end
        @(posedge clk);
        #1;
        sendCompletion(2, 3);
        @(negedge clk);
        checkOutput("busy2_cleared", 64'(busy), 64'(4'b1011));
        checkOutput("decision_bubble", 64'(in_ready), 64'(0));
        @(negedge clk);
        checkOutput("fwd_to_acc2_ready", 64'(in_ready), 64'(1));
        checkOutput("fwd_to_acc2_valid", 64'(acc_in_valid), 64'(4'b0100));
      end
    join
    checkPacket(2);
    checkOutput("busy_refilled", 64'(busy), 64'(4'b1111));

    // Retire accelerator 0 so the completion pointer moves to 1
    mon_q.delete();
    sendCompletion(0, 3);
    checkPacket(0);
    checkOutput("busy_after_acc0", 64'(busy), 64'(4'b1110));

    // Simultaneous completions from 1 and 3 under toggling backpressure
    mon_q.delete();
    fork
      sendCompletion(1, 3);
      sendCompletion(3, 3);
      begin
        for (int c = 0; c < 30; c++) begin
          out_ready = ~out_ready;
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    checkOutput("merged_beats", 64'(mon_q.size()), 64'(6));
    checkPacket(1);
    checkPacket(3);
    checkOutput("busy_after_1_3", 64'(busy), 64'(4'b0100));

    // Retire accelerator 2, then a completion from an idle accelerator
    mon_q.delete();
    sendCompletion(2, 3);
    checkPacket(2);
    checkOutput("busy_all_idle", 64'(busy), 64'(0));
    sendCompletion(1, 3);
    checkPacket(1);
    checkOutput("busy_stray_completion", 64'(busy), 64'(0));

    // Setup packets: one forwarded to accelerator 2, one out of range and dropped
    applyStimulus(setupHdr(8'd2), 3, 2, cyc);
    checkOutput("busy_after_setup", 64'(busy), 64'(0));
    applyStimulus(setupHdr(8'd7), 2, -1, cyc);
    checkOutput("drop_cycles", 64'(cyc), 64'(3));
    checkOutput("busy_after_drop", 64'(busy), 64'(0));
`ifdef SCHED_STATS_EN
    checkOutput("stat_dropped", 64'(stat_dropped), 64'(1));
`endif

    // Reset in the middle of a forwarded task packet
    in_valid = 1'b1;
    in_data  = TASK_HDR | 64'h60_0000;
    in_last  = 1'b0;
    cyc      = 0;
    @(negedge clk);
    while (!in_ready && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
      @(negedge clk);
    end
    checkOutput("mid_pkt_target", 64'(acc_in_valid), 64'(4'b1000));
    @(posedge clk);
    #1;
    in_data = 64'hDA7A_0000_0000_0001;
    checkOutput("mid_pkt_busy", 64'(busy), 64'(4'b1000));
    #2 rstn = 1'b0;
    #1;
    checkOutput("async_rst_in_ready", 64'(in_ready), 64'(0));
    checkOutput("async_rst_acc_in_valid", 64'(acc_in_valid), 64'(0));
    checkOutput("async_rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("async_rst_acc_out_ready", 64'(acc_out_ready), 64'(0));
    checkOutput("async_rst_busy", 64'(busy), 64'(0));
    in_valid = 1'b0;
    in_data  = '0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(TASK_HDR | 64'h70_0000, 3, 0, cyc);
    checkOutput("busy_after_reset_task", 64'(busy), 64'(4'b0001));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_task_scheduler.md
Name: acc_task_scheduler

Overview:
- Shares one task command stream among NUM_ACCS accelerators and merges their completion streams back into one stream.
- Keeps a busy bit per accelerator.
- Dispatches each task packet (header, tid, ptid, args…) to an idle accelerator, chosen round-robin.
- Arbitrates completion packets (cmd 0x03, tid, ptid) packet-atomically onto the single cmd-out stream.
- Sits between the manager's command-in path and the accelerator array.

Parameters:
- NUM_ACCS, 4, number of accelerators; legal range 1..16.
- ACC_ID_BASE, 0, value added to the accelerator index to form the out_id sideband.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- in_valid/in_ready/in_last  in/out/in  1  task command stream from the manager
- in_data  in  64  task command word
- acc_in_valid  out  NUM_ACCS  per-accelerator command valid
- acc_in_ready  in  NUM_ACCS  per-accelerator command ready
- acc_in_data  out  64  command data, shared by all accelerators
- acc_in_last  out  1  command last, shared by all accelerators
- acc_out_valid/acc_out_ready/acc_out_last  in/out/in  NUM_ACCS  completion streams from the accelerators
- acc_out_data  in  64*NUM_ACCS  completion data, accelerator k at bits [64k+63:64k]
- out_valid/out_ready/out_last  out/in/out  1  merged completion stream
- out_data  out  64  merged completion data
- out_id  out  8  ACC_ID_BASE + source index
- out_dest  out  8  constant HWR_CMDOUT_ID
- busy  out  NUM_ACCS  accelerator busy bits

Behaviour:
- Reset (rstn low, asynchronous): dispatch FSM to D_IDLE; completion arbiter to C_IDLE; busy=0; both round-robin pointers=0. All valid/ready outputs are 0 while in reset.
- Dispatch FSM states: D_IDLE, D_FWD, D_DROP.
- D_IDLE, in_ready=0. The header is inspected without being consumed.
  - Header type SETUP_HW_INST_CODE: target = header[ACC_SEL_H:ACC_SEL_L].
    - target >= NUM_ACCS -> D_DROP and increment drop count.
    - Otherwise, if !busy[target] -> D_FWD, with is_task=0.
  - Any other header type: a task.
    - If any busy bit is clear, pick the first clear bit at or after rr_disp (wrapping), latch it as target, set is_task=1, go D_FWD, and set rr_disp = target+1 mod NUM_ACCS.
    - If all accelerators are busy, stall in D_IDLE.
- D_FWD: combinational pass-through of in_* to accelerator target.
  - acc_in_valid[target]=in_valid; in_ready=acc_in_ready[target]; all other acc_in_valid bits are 0.
  - The first beat transferred is the header.
  - If is_task, set busy[target] on the header handshake.
  - On a handshake with in_last -> D_IDLE.
- D_DROP: in_ready=1; consume beats until in_last -> D_IDLE.
- Dispatch latency: one bubble cycle (D_IDLE decision) per packet, then one beat per cycle.
- Completion arbiter states: C_IDLE, C_FWD.
  - C_IDLE: grant the first acc_out_valid at or after rr_cmp; go C_FWD; rr_cmp = grant+1 mod NUM_ACCS. Outputs stay idle in this cycle.
  - C_FWD: pass-through from source grant. The grant is locked until the last-beat handshake.
  - On the last-beat handshake: clear busy[grant] and return to C_IDLE.
  - Non-granted acc_out_ready bits are 0.
- busy updates are registered and take effect the next cycle.
  - A set and a clear of different bits in the same cycle are both applied.
  - A set and a clear of the same bit cannot occur: a busy accelerator is never a task target.
- A completion from a non-busy accelerator is forwarded unchanged, and busy stays 0.
- Backpressure (ready low) holds data stable on all streams; packets are never interleaved.

Optional Feature:
- Macro SCHED_STATS_EN.
- Defined: adds 32-bit outputs stat_dispatched, stat_completed and stat_dropped. These count, respectively, task header handshakes, completion last handshakes and dropped packets. They wrap modulo 2^32 and reset to 0.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package OmpSsManager: SETUP_HW_INST_CODE, CMD_TYPE_H/L, HWR_CMDOUT_ID, new ACC_SEL_H/L (15:8), and the dispatch and completion state enums.
- One sub-module: rr_pick, a combinational "first set bit at or after pointer, with wrap" finder. Instantiated twice, once on ~busy and once on acc_out_valid.

Test Plan (NUM_ACCS=4):
- 1. Reset, then send four 3-beat tasks -> dispatched to accelerators 0,1,2,3 in order; busy=4'b1111.
- 2. Send a fifth task while all are busy -> in_ready stays 0. When accelerator 2's completion last handshakes, the task goes to accelerator 2 one cycle after busy[2] clears.
- 3. Accelerators 1 and 3 assert completions in the same cycle, out_ready toggling 1/0 -> accelerator 1's full packet, then accelerator 3's; no interleaving; out_id=1 then 3; out_dest=HWR_CMDOUT_ID.
- 4. Setup packet with header[15:8]=2 while busy[2]=0 -> forwarded only to accelerator 2; busy unchanged. With header[15:8]=7 -> dropped, 2 beats consumed, and stat_dropped=1 when the feature is enabled.
- 5. Deassert rstn mid-packet, during D_FWD beat 2 -> all valid/ready outputs 0 immediately; busy=0; the next task goes to accelerator 0.
